// File: rtl/pbvi_pkg.sv
// Shared types, constants and Q0.16 helpers for the PBVI belief-update block.
// Optional macro PBVI_BU_ROUND_EN: q16_mul rounds half up instead of truncating.
package pbvi_pkg;

  typedef logic [15:0] prob_t;
  typedef prob_t [1:0] belief_t;

  typedef enum logic [2:0] {
    BU_IDLE    = 3'd0,
    BU_PREDICT = 3'd1,
    BU_WEIGH   = 3'd2,
    BU_DIV     = 3'd3,
    BU_DONE    = 3'd4
  } bu_state_e;

  localparam prob_t ONE_Q16    = 16'hFFFF;
  localparam prob_t UNIFORM0   = 16'h8000;
  localparam prob_t UNIFORM1   = 16'h7FFF;
  localparam int    DIV_CYCLES = 17;

  // Q0.16 product (a*b)>>16, saturating at ONE_Q16
  function automatic prob_t q16_mul(input prob_t a, input prob_t b);
    logic [32:0] w_full;
    w_full = {17'd0, a} * {17'd0, b};
`ifdef PBVI_BU_ROUND_EN
    w_full = w_full + 33'h0_0000_8000;
`endif
    if (w_full[32]) begin
      q16_mul = ONE_Q16;
    end else begin
      q16_mul = w_full[31:16];
    end
  endfunction

  function automatic prob_t q16_sat_add(input prob_t a, input prob_t b);
    logic [16:0] w_sum;
    w_sum = {1'b0, a} + {1'b0, b};
    if (w_sum[16]) begin
      q16_sat_add = ONE_Q16;
    end else begin
      q16_sat_add = w_sum[15:0];
    end
  endfunction

endpackage

// File: rtl/pbvi_div_unit.sv
// 33-bit / 17-bit restoring divider, exactly DIV_CYCLES cycles, saturated 16-bit quotient.
// Requires dividend[32:17] < divisor so the quotient fits in 17 bits.
module pbvi_div_unit
  import pbvi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [32:0] i_dividend,
  input  logic [16:0] i_divisor,
  output logic        o_done,
  output prob_t       o_quot
);

  logic [16:0] r_rem;
  logic [16:0] r_low;
  logic [16:0] r_div;
  logic [15:0] r_quo;
  logic        r_ovf;
  logic        r_busy;
  logic [4:0]  r_cnt;

  logic [17:0] w_shift;
  logic        w_ge;
  logic [16:0] w_rem_n;
  logic [15:0] w_quo_n;
  logic        w_ovf_n;

  // one restoring step; done/quotient are presented during the final step
  always_comb begin
    w_shift = {r_rem, r_low[16]};
    w_ge    = (w_shift >= {1'b0, r_div});
    if (w_ge) begin
      w_rem_n = w_shift[16:0] - r_div;
    end else begin
      w_rem_n = w_shift[16:0];
    end
    w_quo_n = {r_quo[14:0], w_ge};
    w_ovf_n = r_ovf | r_quo[15];
    o_done  = r_busy && (r_cnt == 5'(DIV_CYCLES - 1));
    if (w_ovf_n) begin
      o_quot = ONE_Q16;
    end else begin
      o_quot = w_quo_n;
    end
  end

  // iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= 17'd0;
      r_low  <= 17'd0;
      r_div  <= 17'd0;
      r_quo  <= 16'd0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= 5'd0;
    end else if (i_start) begin
      r_rem  <= {1'b0, i_dividend[32:17]};
      r_low  <= i_dividend[16:0];
      r_div  <= i_divisor;
      r_quo  <= 16'd0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b1;
      r_cnt  <= 5'd0;
    end else if (r_busy) begin
      r_rem  <= w_rem_n;
      r_low  <= {r_low[15:0], 1'b0};
      r_quo  <= w_quo_n;
      r_ovf  <= w_ovf_n;
      r_cnt  <= r_cnt + 5'd1;
      r_busy <= !o_done;
    end
  end

endmodule

// File: rtl/pbvi_belief_update.sv
// Bayesian 2-state belief update: predict through T, weigh by O, normalise by division.
// Optional macro PBVI_BU_ROUND_EN selects round-half-up Q0.16 products.
module pbvi_belief_update
  import pbvi_pkg::*;
#(
  parameter int N_ACT = 4,
  parameter int N_OBS = 4,
  parameter int W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [$clog2(N_ACT)-1:0]              action,
  input  logic [$clog2(N_OBS)-1:0]              obs,
  input  logic [1:0][W-1:0]                     cur_belief,
  input  logic [N_ACT-1:0][1:0][1:0][W-1:0]     trans,
  input  logic [N_ACT-1:0][1:0][N_OBS-1:0][W-1:0] obs_prob,
  output logic                                  busy,
  output logic [1:0][W-1:0]                     new_belief,
  output logic                                  out_valid,
  output logic                                  degenerate,
  output logic                                  en_decision
);

  bu_state_e                 r_state;
  bu_state_e                 w_state_n;
  logic [$clog2(N_ACT)-1:0]  r_act;
  logic [$clog2(N_OBS)-1:0]  r_obs;
  belief_t                   r_b;
  belief_t                   r_p;
  belief_t                   r_new;
  logic                      r_busy;
  logic                      r_valid;
  logic                      r_deg;
  logic                      r_en;

  belief_t                   w_p;
  belief_t                   w_u;
  logic [16:0]               w_sum;
  logic                      w_degen;
  logic                      w_div_start;
  logic                      w_div_done;
  prob_t                     w_quot;

  // predict and weigh datapath; tables are only consumed in PREDICT/WEIGH
  always_comb begin
    w_p = '0;
    w_u = '0;
    for (int sp = 0; sp < 2; sp++) begin
      w_p[sp] = q16_sat_add(q16_mul(trans[r_act][0][sp], r_b[0]),
                            q16_mul(trans[r_act][1][sp], r_b[1]));
      w_u[sp] = q16_mul(r_p[sp], obs_prob[r_act][sp][r_obs]);
    end
    w_sum   = {1'b0, w_u[0]} + {1'b0, w_u[1]};
    w_degen = (r_state == BU_WEIGH) && (w_sum == 17'd0);
  end

  // next-state logic
  always_comb begin
    w_state_n   = r_state;
    w_div_start = 1'b0;
    case (r_state)
      BU_IDLE: begin
        if (start) w_state_n = BU_PREDICT;
        else       w_state_n = BU_IDLE;
      end
      BU_PREDICT: w_state_n = BU_WEIGH;
      BU_WEIGH: begin
        if (w_sum == 17'd0) begin
          w_state_n = BU_DONE;
        end else begin
          w_state_n   = BU_DIV;
          w_div_start = 1'b1;
        end
      end
      BU_DIV: begin
        if (w_div_done) w_state_n = BU_DONE;
        else            w_state_n = BU_DIV;
      end
      BU_DONE: w_state_n = BU_IDLE;
      default: w_state_n = BU_IDLE;
    endcase
  end

  pbvi_div_unit u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend ({1'b0, w_u[0], 16'h0000}),
    .i_divisor  (w_sum),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // state, operand latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BU_IDLE;
      r_act   <= '0;
      r_obs   <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_new   <= {UNIFORM1, UNIFORM0};
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_deg   <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != BU_IDLE);
      r_valid <= (w_state_n == BU_DONE);
      r_en    <= (w_state_n == BU_DONE);
      r_deg   <= w_degen;
      if (r_state == BU_IDLE && start) begin
        r_act <= action;
        r_obs <= obs;
        r_b   <= cur_belief;
      end
      if (r_state == BU_PREDICT) r_p <= w_p;
      if (w_degen) begin
        r_new <= {UNIFORM1, UNIFORM0};
      end else if (w_div_done) begin
        r_new <= {ONE_Q16 - w_quot, w_quot};
      end
    end
  end

  assign busy        = r_busy;
  assign new_belief  = r_new;
  assign out_valid   = r_valid;
  assign degenerate  = r_deg;
  assign en_decision = r_en;

endmodule
